// File: rtl/lsu_mem_master.sv
// Load/store initiator for a doubleword data-memory port.
// Accepts one access at a time, splits doubleword-crossing accesses into two beats and extends load data.
module lsu_mem_master #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_raddr,
    output logic        mem_read,
    input  logic [63:0] mem_rdata,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        mem_write
);
    localparam int unsigned XLEN  = 64;
    localparam int unsigned NBYTE = XLEN / 8;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t state, state_d;

    logic             wen_q, wen_d, uns_q, uns_d, cross_q, cross_d;
    logic [2:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic [XLEN-1:0]  base_q, base_d, wdata_q, wdata_d, lo_q, lo_d;

    logic             req_ready_d, resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
    logic [XLEN-1:0]  resp_rdata_d, mem_raddr_d, mem_waddr_d, mem_wdata_d;
    logic [NBYTE-1:0] mem_wmask_d;

    logic [2:0]        src_off;
    logic [1:0]        src_size;
    logic [XLEN-1:0]   src_wdata;
    logic [3:0]        src_nbytes;
    logic              src_cross;
    logic [2*XLEN-1:0] lane_w;
    logic [2*NBYTE-1:0] lane_m;
    logic [2*XLEN-1:0] rd_cat;
    logic [XLEN-1:0]   rd_low, load_val;

    // Lane placement uses the live request in IDLE and the latched one afterwards
    always_comb begin
        src_off    = (state == IDLE) ? req_addr[2:0] : off_q;
        src_size   = (state == IDLE) ? req_size : size_q;
        src_wdata  = (state == IDLE) ? req_wdata : wdata_q;
        src_nbytes = 4'(1) << src_size;
        src_cross  = (4'(src_off) + src_nbytes) > 4'd8;
        lane_w     = {{XLEN{1'b0}}, src_wdata} << {src_off, 3'b000};
        lane_m     = (((2*NBYTE)'(1) << src_nbytes) - (2*NBYTE)'(1)) << src_off;
    end

    // Load extraction: hi beat is the live read in ACC1, zero otherwise
    always_comb begin
        rd_cat = (state == ACC1) ? {mem_rdata, lo_q} : {{XLEN{1'b0}}, mem_rdata};
        rd_low = XLEN'(rd_cat >> {off_q, 3'b000});
        case (size_q)
            2'd0:    load_val = uns_q ? {56'b0, rd_low[7:0]}  : {{56{rd_low[7]}},  rd_low[7:0]};
            2'd1:    load_val = uns_q ? {48'b0, rd_low[15:0]} : {{48{rd_low[15]}}, rd_low[15:0]};
            2'd2:    load_val = uns_q ? {32'b0, rd_low[31:0]} : {{32{rd_low[31]}}, rd_low[31:0]};
            default: load_val = rd_low;
        endcase
    end

    always_comb begin
        state_d      = state;
        wen_d        = wen_q;
        uns_d        = uns_q;
        cross_d      = cross_q;
        off_d        = off_q;
        size_d       = size_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_raddr_d  = '0;
        mem_waddr_d  = '0;
        mem_wdata_d  = '0;
        mem_wmask_d  = '0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    wen_d   = req_wen;
                    uns_d   = req_unsigned;
                    cross_d = src_cross;
                    off_d   = req_addr[2:0];
                    size_d  = req_size;
                    base_d  = {req_addr[XLEN-1:3], 3'b000};
                    wdata_d = req_wdata;
                    if (src_cross && !SPLIT_EN) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d = ACC0;
                        if (req_wen) begin
                            mem_write_d = 1'b1;
                            mem_waddr_d = {req_addr[XLEN-1:3], 3'b000};
                            mem_wdata_d = lane_w[XLEN-1:0];
                            mem_wmask_d = lane_m[NBYTE-1:0];
                        end else begin
                            mem_read_d  = 1'b1;
                            mem_raddr_d = {req_addr[XLEN-1:3], 3'b000};
                        end
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ACC0: begin
                if (!wen_q) lo_d = mem_rdata;
                if (cross_q) begin
                    state_d = ACC1;
                    if (wen_q) begin
                        mem_write_d = 1'b1;
                        mem_waddr_d = base_q + XLEN'(NBYTE);
                        mem_wdata_d = lane_w[2*XLEN-1:XLEN];
                        mem_wmask_d = lane_m[2*NBYTE-1:NBYTE];
                    end else begin
                        mem_read_d  = 1'b1;
                        mem_raddr_d = base_q + XLEN'(NBYTE);
                    end
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = wen_q ? '0 : load_val;
                end
            end
            ACC1: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = wen_q ? '0 : load_val;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = resp_err;
                    resp_rdata_d = resp_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wen_q      <= 1'b0;
            uns_q      <= 1'b0;
            cross_q    <= 1'b0;
            off_q      <= '0;
            size_q     <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_raddr  <= '0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
        end else begin
            state      <= state_d;
            wen_q      <= wen_d;
            uns_q      <= uns_d;
            cross_q    <= cross_d;
            off_q      <= off_d;
            size_q     <= size_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            lo_q       <= lo_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            mem_read   <= mem_read_d;
            mem_write  <= mem_write_d;
            mem_raddr  <= mem_raddr_d;
            mem_waddr  <= mem_waddr_d;
            mem_wdata  <= mem_wdata_d;
            mem_wmask  <= mem_wmask_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: a split-enabled instance with a small memory image
// and a split-disabled instance for the reject path.
module tb_lsu_mem_master;
    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic [63:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic        mem_read, mem_write;
    logic [7:0]  mem_wmask;

    logic        b_req_valid, b_req_ready, b_req_wen, b_req_unsigned;
    logic [63:0] b_req_addr, b_req_wdata;
    logic [1:0]  b_req_size;
    logic        b_resp_valid, b_resp_ready, b_resp_err;
    logic [63:0] b_resp_rdata;
    logic [63:0] b_mem_raddr, b_mem_rdata, b_mem_waddr, b_mem_wdata;
    logic        b_mem_read, b_mem_write;
    logic [7:0]  b_mem_wmask;

    logic [63:0] mem_img [2];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    // Two doublewords at 0x80000000 and 0x80000008
    assign mem_rdata   = mem_read ? mem_img[mem_raddr[3]] : 64'd0;
    assign b_mem_rdata = b_mem_read ? 64'hCAFE_F00D_1234_5678 : 64'd0;

    lsu_mem_master #(.SPLIT_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_raddr(mem_raddr), .mem_read(mem_read), .mem_rdata(mem_rdata),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_write(mem_write)
    );

    lsu_mem_master #(.SPLIT_EN(1'b0)) u_nosplit (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_size(b_req_size),
        .req_unsigned(b_req_unsigned),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_raddr(b_mem_raddr), .mem_read(b_mem_read), .mem_rdata(b_mem_rdata),
        .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
        .mem_write(b_mem_write)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Presents a request and returns at the negedge of the first cycle after acceptance
    task automatic issue(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input logic uns);
        int n;
        n = 0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_wait", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
        req_wdata = 64'hA5A5_A5A5_A5A5_A5A5;
    endtask

    initial begin
        logic seen_resp;
        int   n;
        rst_n = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = '0; req_unsigned = 1'b0; resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_wen = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_req_size = '0; b_req_unsigned = 1'b0; b_resp_ready = 1'b1;
        mem_img[0] = '0;
        mem_img[1] = '0;

        repeat (2) @(negedge clk);
        check("rst_req_ready",  64'(req_ready),  64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mem_read",   64'(mem_read),   64'd0);
        check("rst_mem_write",  64'(mem_write),  64'd0);
        check("rst_mem_raddr",  mem_raddr,       64'd0);
        check("rst_mem_wmask",  64'(mem_wmask),  64'd0);
        check("rst_resp_rdata", resp_rdata,      64'd0);
        rst_n = 1'b1;

        // Aligned double load
        mem_img[0] = 64'h1122_3344_5566_7788;
        issue(1'b0, 64'h8000_0000, 64'd0, 2'd3, 1'b0);
        check("ld64_read",  64'(mem_read),  64'd1);
        check("ld64_raddr", mem_raddr,      64'h8000_0000);
        check("ld64_nowr",  64'(mem_write), 64'd0);
        check("ld64_t1_rv", 64'(resp_valid), 64'd0);
        @(negedge clk);
        check("ld64_rv",    64'(resp_valid), 64'd1);
        check("ld64_data",  resp_rdata,     64'h1122_3344_5566_7788);
        check("ld64_rd_off", 64'(mem_read), 64'd0);
        check("ld64_rr",    64'(req_ready), 64'd0);
        @(negedge clk);
        check("ld64_done_rv", 64'(resp_valid), 64'd0);
        check("ld64_done_rr", 64'(req_ready),  64'd1);

        // Signed and unsigned byte load
        mem_img[0] = 64'h0000_0000_8000_0000;
        issue(1'b0, 64'h8000_0003, 64'd0, 2'd0, 1'b0);
        check("lbs_raddr", mem_raddr, 64'h8000_0000);
        @(negedge clk);
        check("lbs_data",  resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        issue(1'b0, 64'h8000_0003, 64'd0, 2'd0, 1'b1);
        check("lbu_raddr", mem_raddr, 64'h8000_0000);
        @(negedge clk);
        check("lbu_data",  resp_rdata, 64'h0000_0000_0000_0080);

        // Half store in the top lanes
        issue(1'b1, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 2'd1, 1'b0);
        check("sh_write", 64'(mem_write), 64'd1);
        check("sh_noread", 64'(mem_read), 64'd0);
        check("sh_waddr", mem_waddr, 64'h8000_0000);
        check("sh_wmask", 64'(mem_wmask), 64'h0000_0000_0000_00C0);
        check("sh_wdata", mem_wdata, 64'hBEEF_0000_0000_0000);
        @(negedge clk);
        check("sh_rv",    64'(resp_valid), 64'd1);
        check("sh_rdata", resp_rdata, 64'd0);
        check("sh_wr_off", 64'(mem_write), 64'd0);
        check("sh_waddr_off", mem_waddr, 64'd0);

        // Split word load across 0x80000008
        mem_img[0] = 64'h2211_0000_0000_0000;
        mem_img[1] = 64'h0000_0000_0000_4433;
        issue(1'b0, 64'h8000_0006, 64'd0, 2'd2, 1'b0);
        check("lw_split_raddr0", mem_raddr, 64'h8000_0000);
        @(negedge clk);
        check("lw_split_read1",  64'(mem_read), 64'd1);
        check("lw_split_raddr1", mem_raddr, 64'h8000_0008);
        check("lw_split_t2_rv",  64'(resp_valid), 64'd0);
        @(negedge clk);
        check("lw_split_rv",   64'(resp_valid), 64'd1);
        check("lw_split_data", resp_rdata, 64'h0000_0000_4433_2211);

        // Split double store
        issue(1'b1, 64'h8000_0005, 64'h0102_0304_0506_0708, 2'd3, 1'b0);
        check("sd_b0_waddr", mem_waddr, 64'h8000_0000);
        check("sd_b0_wmask", 64'(mem_wmask), 64'h0000_0000_0000_00E0);
        check("sd_b0_wdata", mem_wdata, 64'h0607_0800_0000_0000);
        @(negedge clk);
        check("sd_b1_write", 64'(mem_write), 64'd1);
        check("sd_b1_waddr", mem_waddr, 64'h8000_0008);
        check("sd_b1_wmask", 64'(mem_wmask), 64'h0000_0000_0000_001F);
        check("sd_b1_wdata", mem_wdata, 64'h0000_0001_0203_0405);
        @(negedge clk);
        check("sd_rv", 64'(resp_valid), 64'd1);
        check("sd_rdata", resp_rdata, 64'd0);

        // Repeat, with reset pulsed during the second beat
        issue(1'b1, 64'h8000_0005, 64'h0102_0304_0506_0708, 2'd3, 1'b0);
        @(negedge clk);
        check("sdr_b1_write", 64'(mem_write), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("sdr_rst_write", 64'(mem_write), 64'd0);
        check("sdr_rst_waddr", mem_waddr, 64'd0);
        check("sdr_rst_rr",    64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
        end
        check("sdr_no_resp", 64'(seen_resp), 64'd0);

        // Backpressure: response held stable, no new request accepted
        resp_ready = 1'b0;
        mem_img[0] = 64'h89AB_CDEF_0000_0000;
        issue(1'b0, 64'h8000_0004, 64'd0, 2'd2, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_rv",    64'(resp_valid), 64'd1);
            check("bp_rdata", resp_rdata, 64'hFFFF_FFFF_89AB_CDEF);
            check("bp_rr",    64'(req_ready), 64'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_done_rv", 64'(resp_valid), 64'd0);
        check("bp_done_rr", 64'(req_ready),  64'd1);

        // Split-disabled instance: crossing load is rejected one cycle after accept
        @(negedge clk);
        b_req_valid = 1'b1; b_req_wen = 1'b0; b_req_addr = 64'h8000_0006; b_req_size = 2'd2;
        n = 0;
        while (!b_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rej_req_ready", 64'(b_req_ready), 64'd1);
        @(negedge clk);
        b_req_valid = 1'b0;
        check("rej_rv",    64'(b_resp_valid), 64'd1);
        check("rej_err",   64'(b_resp_err),   64'd1);
        check("rej_read",  64'(b_mem_read),   64'd0);
        check("rej_write", 64'(b_mem_write),  64'd0);
        check("rej_rdata", b_resp_rdata,      64'd0);
        @(negedge clk);
        check("rej_done_rv",  64'(b_resp_valid), 64'd0);
        check("rej_done_err", 64'(b_resp_err),   64'd0);

        // Size 3 at offset 0 never crosses, so it is not rejected
        b_req_valid = 1'b1; b_req_addr = 64'h8000_0010; b_req_size = 2'd3;
        n = 0;
        while (!b_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        b_req_valid = 1'b0;
        check("ns64_read",  64'(b_mem_read), 64'd1);
        check("ns64_raddr", b_mem_raddr, 64'h8000_0010);
        @(negedge clk);
        check("ns64_err",   64'(b_resp_err), 64'd0);
        check("ns64_data",  b_resp_rdata, 64'hCAFE_F00D_1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the core's doubleword data-memory port: raddr/read/waddr/wdata/wmask/write out, rdata back in.
- Accepts one load or store at a time from the execute stage over a valid/ready handshake.
- Aligns every memory access to 8 bytes, splits accesses that cross a doubleword boundary into two beats, and returns sign- or zero-extended load data over a valid/ready response channel.

Parameters:
- SPLIT_EN, 1: 1 = a boundary-crossing access runs as two memory beats. 0 = it is rejected with resp_err, no memory access.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  64  byte address
- req_wdata  in  64  store data, low-justified
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- req_unsigned  in  1  zero-extend load (ignored for stores)
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when valid&ready
- resp_rdata  out  64  extended load data; 0 for stores
- resp_err  out  1  boundary-crossing access rejected (SPLIT_EN=0 only)
- mem_raddr  out  64  doubleword-aligned read address
- mem_read  out  1  read strobe
- mem_rdata  in  64  read data, valid in the same cycle mem_read is high
- mem_waddr  out  64  doubleword-aligned write address
- mem_wdata  out  64  write data, lane-positioned
- mem_wmask  out  8  byte enables
- mem_write  out  1  write strobe; memory commits once per cycle it is high

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - req_ready=0 while rst_n=0.
  - resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_raddr, mem_waddr, mem_wdata, mem_wmask are all 0.
- Request latch: on acceptance, latch off=addr[2:0], nbytes=1<<size, base=addr&~7, cross=(off+nbytes>8).
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1; all mem strobes 0.
  - On req_valid, latch the request.
  - If cross&&!SPLIT_EN, go to RESP with err=1.
  - Otherwise go to ACC0.
- ACC0:
  - Load: mem_read=1, mem_raddr=base; capture mem_rdata into lo.
  - Store: mem_write=1, mem_waddr=base, mem_wdata=W[63:0], mem_wmask=M[7:0].
  - W = {64'b0,wdata} << (off*8) over 128 bits. M = ((1<<nbytes)-1) << off over 16 bits.
  - Next state is ACC1 if cross, else RESP.
- ACC1:
  - Same as ACC0 with address base+8 (64-bit wrap), W[127:64], M[15:8].
  - Load captures mem_rdata into hi.
  - Next state is RESP.
- RESP:
  - resp_valid=1.
  - Load: resp_rdata = low nbytes of ({hi,lo} >> off*8), sign-extended unless req_unsigned. hi=0 when not crossing.
  - resp_rdata and resp_err are held stable until resp_ready; then go to IDLE.
  - req_ready=0; no new request is accepted in the handshake cycle.
- Strobe rules:
  - Exactly one mem strobe is high in ACC0/ACC1; none are high in IDLE/RESP.
  - Addresses and data outputs are 0 whenever their strobe is 0.
- Latency:
  - Non-crossing: accept at cycle T, access at T+1, resp_valid at T+2.
  - Crossing: resp_valid at T+3.
  - Rejected: resp_valid at T+1.
- Size 3 with off=0 never crosses. Any nonzero off with size 3 crosses.
- resp_ready held high before RESP has no effect.
- Reset mid-operation:
  - The FSM aborts immediately; strobes drop in the same cycle.
  - For a split store reset after ACC0, the low beat remains written. This is accepted behaviour; no rollback.
- Inputs other than resp_ready are ignored outside IDLE.

Test Plan:
- Aligned double load:
  - Memory at 0x80000000 = 0x1122334455667788.
  - Load size=3 addr=0x80000000 -> one read at 0x80000000, resp_rdata=0x1122334455667788 two cycles after accept.
- Signed/unsigned byte load:
  - Byte at 0x80000003 = 0x80.
  - Signed -> 0xFFFFFFFFFFFFFF80. Unsigned -> 0x0000000000000080.
  - Read address 0x80000000 in both cases.
- Half store:
  - Store size=1 addr=0x80000006 wdata=0xBEEF -> single beat, waddr=0x80000000, wmask=0xC0, wdata=0xBEEF000000000000.
- Split word load (SPLIT_EN=1):
  - Load size=2 addr=0x80000006; bytes 06..09 = 0x11,0x22,0x33,0x44.
  - Reads at 0x80000000 then 0x80000008; resp_rdata=0x44332211 at T+3.
- Split double store:
  - Store size=3 addr=0x80000005 wdata=0x0102030405060708.
  - Beat 1: wmask=0xE0, wdata=0x060708xx... (bytes 5..7 = 0x08,0x07,0x06).
  - Beat 2: waddr=0x80000008, wmask=0x1F.
  - Then pulse rst_n low during beat 2 in a repeat run: mem_write drops at once, resp_valid never asserts.
- Backpressure and reject:
  - Hold resp_ready=0 for 5 cycles: resp_valid and resp_rdata stay stable, req_ready stays 0.
  - With SPLIT_EN=0, crossing load -> resp_err=1 at T+1, no mem strobes.
